// File: rtl/phase_timer.sv
// phase_timer: latches a one-hot arbiter grant as the active light phase, holds it
// for the programmed duration, then enforces an all-red clearance interval.
// Optional feature macro: PHASE_TIMER_PREEMPT_EN (emergency preemption of a running phase).
module phase_timer #(
    parameter int unsigned DUR_W        = 8,
    parameter int unsigned CLEAR_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [8:0]         sel,
    input  logic [9*DUR_W-1:0] durations,
    output logic [8:0]         phase,
    output logic               busy,
    output logic               grant_ack,
    output logic               phase_done,
    output logic               preempted,
    output logic               sel_err
);

    typedef enum logic [1:0] {StIdle, StRun, StClear} state_e;

    localparam logic [7:0] ClrLoad = 8'(CLEAR_CYCLES - 1);

    state_e             state_q, state_d;
    logic [8:0]         phase_q, phase_d;
    logic [DUR_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         clr_q, clr_d;
    logic               busy_q, busy_d;
    logic               ack_q, ack_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               pend_q;
    logic               sel_onehot;
    logic [DUR_W-1:0]   dur_sel;

`ifdef PHASE_TIMER_PREEMPT_EN
    logic               pend_d;
    logic               pre_q, pre_d;
`endif

    // Duration 0 is treated as 1, so the counter load is max(d,1)-1.
    function automatic logic [DUR_W-1:0] load_val(input logic [DUR_W-1:0] d);
        return (d == '0) ? '0 : d - DUR_W'(1);
    endfunction

    // Grant decode: exactly one bit set, and the matching duration field.
    always_comb begin
        sel_onehot = (sel != '0) && ((sel & (sel - 9'd1)) == '0);
        dur_sel    = '0;
        for (int i = 0; i < 9; i++) begin
            if (sel[i]) dur_sel = durations[i*DUR_W +: DUR_W];
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        clr_d   = clr_q;
        ack_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef PHASE_TIMER_PREEMPT_EN
        pend_d  = pend_q;
        pre_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (sel_onehot) begin
                    state_d = StRun;
                    phase_d = sel;
                    cnt_d   = load_val(dur_sel);
                    ack_d   = 1'b1;
                end else if (sel != '0) begin
                    err_d = 1'b1;
                end
            end
            StRun: begin
`ifdef PHASE_TIMER_PREEMPT_EN
                if (!phase_q[8] && sel[8]) begin
                    state_d = StClear;
                    phase_d = '0;
                    clr_d   = ClrLoad;
                    pre_d   = 1'b1;
                    pend_d  = 1'b1;
                end else
`endif
                if (cnt_q == '0) begin
                    state_d = StClear;
                    phase_d = '0;
                    clr_d   = ClrLoad;
                end else begin
                    cnt_d = cnt_q - DUR_W'(1);
                end
            end
            StClear: begin
                if (clr_q == '0) begin
                    done_d = 1'b1;
                    if (pend_q) begin
                        // Emergency runs straight after clearance, skipping IDLE.
                        state_d = StRun;
                        phase_d = 9'h100;
                        cnt_d   = load_val(durations[8*DUR_W +: DUR_W]);
                        ack_d   = 1'b1;
`ifdef PHASE_TIMER_PREEMPT_EN
                        pend_d  = 1'b0;
`endif
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    clr_d = clr_q - 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                phase_d = '0;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            phase_q <= '0;
            cnt_q   <= '0;
            clr_q   <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            clr_q   <= clr_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef PHASE_TIMER_PREEMPT_EN
    // Pending-emergency flag and preemption pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            pre_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            pre_q  <= pre_d;
        end
    end
    assign preempted = pre_q;
`else
    assign pend_q    = 1'b0;
    assign preempted = 1'b0;
`endif

    assign phase      = phase_q;
    assign busy       = busy_q;
    assign grant_ack  = ack_q;
    assign phase_done = done_q;
    assign sel_err    = err_q;

endmodule

// File: tb/tb_phase_timer.sv
// Self-checking bench for phase_timer: a per-cycle vector table for the nominal,
// zero-duration, malformed, ignore-in-RUN and back-to-back cases, plus hand-written
// sequences for reset release, preemption (either build) and async reset mid-RUN.
module tb_phase_timer;

    localparam int unsigned DUR_W = 8;

    logic               clk;
    logic               rst_n;
    logic [8:0]         sel;
    logic [9*DUR_W-1:0] durations;
    logic [8:0]         phase;
    logic               busy, grant_ack, phase_done, preempted, sel_err;

    int n_checks = 0;
    int n_fail   = 0;

    phase_timer #(.DUR_W(DUR_W), .CLEAR_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel        (sel),
        .durations  (durations),
        .phase      (phase),
        .busy       (busy),
        .grant_ack  (grant_ack),
        .phase_done (phase_done),
        .preempted  (preempted),
        .sel_err    (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] sel;
        logic [8:0] phase;
        logic       busy;
        logic       ack;
        logic       done;
        logic       err;
    } vec_t;

    vec_t vecs[28];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [13:0] outs();
        return {phase, busy, grant_ack, phase_done, preempted, sel_err};
    endfunction

    // Hold reset across a couple of edges, release mid-cycle with the given sel.
    task automatic do_reset(input logic [8:0] s);
        rst_n = 1'b0;
        sel   = s;
        step();
        step();
        check("reset_outputs", 32'(outs()), 32'd0);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        int hi;
        bit seen_pre, seen_done;

        rst_n = 1'b0;
        sel   = '0;
        for (int i = 0; i < 9; i++) durations[i*DUR_W +: DUR_W] = 8'd3;
        durations[0*DUR_W +: DUR_W] = 8'd0;
        durations[1*DUR_W +: DUR_W] = 8'd20;
        durations[2*DUR_W +: DUR_W] = 8'd5;
        durations[8*DUR_W +: DUR_W] = 8'd2;

        //             sel     phase   busy  ack   done  err
        vecs[0]  = '{9'h004, 9'h004, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{9'h000, 9'h004, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{9'h000, 9'h004, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{9'h000, 9'h004, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{9'h000, 9'h004, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{9'h000, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{9'h000, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{9'h000, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{9'h000, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{9'h000, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{9'h081, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{9'h001, 9'h001, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{9'h000, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{9'h000, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{9'h000, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{9'h000, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{9'h000, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[18] = '{9'h010, 9'h010, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{9'h020, 9'h010, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{9'h030, 9'h010, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[21] = '{9'h000, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[22] = '{9'h000, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[23] = '{9'h000, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[24] = '{9'h000, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[25] = '{9'h000, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[26] = '{9'h004, 9'h004, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[27] = '{9'h000, 9'h004, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset with a pending grant: accepted one edge after release.
        do_reset(9'h001);
        step();
        check("release_phase", 32'(phase), 32'h001);
        check("release_ack", 32'(grant_ack), 32'd1);

        // Table-driven vectors from a clean IDLE.
        do_reset(9'h000);
        step();
        check("idle_after_reset", 32'(outs()), 32'd0);
        for (int i = 0; i < 28; i++) begin
            sel = vecs[i].sel;
            step();
            n_checks++;
            if (outs() !== {vecs[i].phase, vecs[i].busy, vecs[i].ack, vecs[i].done,
                            1'b0, vecs[i].err}) begin
                n_fail++;
                $display("FAIL vec%0d: got phase=%h busy=%b ack=%b done=%b pre=%b err=%b expected phase=%h busy=%b ack=%b done=%b pre=0 err=%b",
                         i, phase, busy, grant_ack, phase_done, preempted, sel_err,
                         vecs[i].phase, vecs[i].busy, vecs[i].ack, vecs[i].done, vecs[i].err);
            end
        end

        // Emergency request during a long phase 9'h002.
        do_reset(9'h000);
        step();
        sel = 9'h002;
        step();
        check("pre_accept", 32'(phase), 32'h002);
        sel = 9'h000;
        step();
        sel = 9'h100;
`ifdef PHASE_TIMER_PREEMPT_EN
        step();
        check("pre_pulse", 32'({phase, busy, preempted}), 32'({9'h000, 1'b1, 1'b1}));
        sel = 9'h000;
        for (int k = 0; k < 3; k++) begin
            step();
            check("pre_clear", 32'({phase, busy, preempted, phase_done}),
                  32'({9'h000, 1'b1, 1'b0, 1'b0}));
        end
        step();
        check("pre_emerg", 32'({phase, grant_ack, phase_done}), 32'({9'h100, 1'b1, 1'b1}));
        step();
        check("pre_emerg2", 32'({phase, grant_ack}), 32'({9'h100, 1'b0}));
        step();
        check("pre_emerg_end", 32'(phase), 32'h000);
`else
        hi = 2;
        seen_pre = 1'b0;
        for (int k = 0; k < 40 && phase == 9'h002; k++) begin
            step();
            if (preempted) seen_pre = 1'b1;
            if (phase == 9'h002) hi++;
        end
        check("nopre_len", 32'(hi), 32'd20);
        check("nopre_flag", 32'(seen_pre), 32'd0);
        for (int k = 0; k < 3; k++) step();
        check("nopre_clear", 32'({phase, phase_done}), 32'({9'h000, 1'b0}));
        step();
        check("nopre_done", 32'({phase, phase_done}), 32'({9'h000, 1'b1}));
        step();
        check("nopre_emerg", 32'({phase, grant_ack}), 32'({9'h100, 1'b1}));
`endif

        // Async reset dropped between edges in the middle of RUN.
        do_reset(9'h000);
        step();
        sel = 9'h004;
        step();
        sel = 9'h000;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_phase", 32'(phase), 32'h000);
        check("async_busy", 32'(busy), 32'd0);
        step();
        #3;
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (phase_done) seen_done = 1'b1;
        end
        check("async_no_done", 32'(seen_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
